uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous serial line into 8-bit bytes, using a 16x oversampling tick from the shared baud generator. It is the receive half of the UART controller and sits between the pad-side rx line and the RX FIFO / AXI-Lite register block. Frame format: 1 start bit, 8 data bits LSB first, optional odd/even parity bit, 1 stop bit. Results are reported with a one-cycle done strobe plus parity and framing error flags.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive deserialiser: 16x-oversampled start/8 data/optional parity/stop framing.
// Reports each frame with a one-cycle rx_done strobe plus parity and framing error flags.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       a_resetn,
  input  logic       b_tick,
  input  logic       rx,
  input  logic [1:0] parity,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              acc_q, acc_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic              par_flag_q, par_flag_d;
  logic              armed_q, armed_d;
  logic [7:0]        rx_data_d;
  logic              rx_done_d, parity_err_d, frame_err_d, rx_busy_d;

  // Metastability synchroniser; flops idle high like the line itself.
  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) sync_q <= '1;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      par_mode_q <= 2'b00;
      par_flag_q <= 1'b0;
      armed_q    <= 1'b1;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      par_mode_q <= par_mode_d;
      par_flag_q <= par_flag_d;
      armed_q    <= armed_d;
      rx_data    <= rx_data_d;
      rx_done    <= rx_done_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      rx_busy    <= rx_busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    par_mode_d   = par_mode_q;
    par_flag_d   = par_flag_q;
    armed_d      = armed_q;
    rx_data_d    = rx_data;
    rx_done_d    = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (rx_s) armed_d = 1'b1;
        // A tick coinciding with this edge is deliberately not counted.
        if (armed_q && !rx_s) begin
          state_d    = S_START;
          acc_d      = 1'b0;
          par_flag_d = 1'b0;
          par_mode_d = parity;
        end
      end
      S_START: begin
        if (b_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            acc_d   = acc_q ^ rx_s;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = (par_mode_q == PAR_ODD || par_mode_q == PAR_EVEN) ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_PARITY: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            par_flag_d = (par_mode_q == PAR_ODD) ? (rx_s != ~acc_q) : (rx_s != acc_q);
            state_d    = S_STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      S_STOP: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            rx_data_d    = shift_q;
            parity_err_d = par_flag_q;
            frame_err_d  = ~rx_s;
            rx_done_d    = 1'b1;
            state_d      = S_IDLE;
            // Disarm on a low stop bit so a break cannot retrigger.
            if (!rx_s) armed_d = 1'b0;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bench-side serial transmitter model feeding a frame scoreboard.
module tb_uart_rx;

  localparam int unsigned OS = 16;

  logic       clk;
  logic       a_resetn;
  logic       b_tick;
  logic       rx;
  logic [1:0] parity;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t exp_q[$];
  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int tick_div = 4;
  int div_cnt  = 0;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .a_resetn   (a_resetn),
    .b_tick     (b_tick),
    .rx         (rx),
    .parity     (parity),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of progress: sample on the falling edge, score any rx_done, then drive the next tick.
  task automatic cycle();
    frame_t e;
    @(negedge clk);
    if (rx_done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rx_done with rx_data=%02h but no frame expected", rx_data);
      end else begin
        e = exp_q.pop_front();
        if ({rx_data, parity_err, frame_err} !== {e.data, e.perr, e.ferr}) begin
          errors++;
          $display("FAIL sb_frame: got data=%02h perr=%b ferr=%b, expected data=%02h perr=%b ferr=%b",
                   rx_data, parity_err, frame_err, e.data, e.perr, e.ferr);
        end
      end
    end
    b_tick  = (div_cnt == tick_div - 1);
    div_cnt = b_tick ? 0 : div_cnt + 1;
  endtask

  task automatic send_bit(input logic v);
    int n = 0;
    rx = v;
    while (n < int'(OS)) begin
      cycle();
      if (b_tick) n++;
    end
  endtask

  function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] mode);
    return (mode == 2'b01) ? ~(^d) : (^d);
  endfunction

  // Transmitter model: pushes the expected result, then drives the full frame.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic pbit, input logic stop);
    frame_t e;
    e.data = d;
    e.ferr = ~stop;
    case (mode)
      2'b01:   e.perr = ~(^d ^ pbit);
      2'b10:   e.perr = ^d ^ pbit;
      default: e.perr = 1'b0;
    endcase
    exp_q.push_back(e);
    parity = mode;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (mode == 2'b01 || mode == 2'b10) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_busy !== 1'b0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: pending=%0d rx_busy=%b, expected pending=0 rx_busy=0",
               tag, exp_q.size(), rx_busy);
    end
  endtask

  task automatic test_reset();
    a_resetn = 1'b0;
    rx       = 1'b1;
    b_tick   = 1'b0;
    parity   = 2'b00;
    repeat (4) cycle();
    checks += 5;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
    if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    a_resetn = 1'b1;
    repeat (8) cycle();
  endtask

  task automatic test_basic();
    int base = done_cnt;
    tick_div = 4;
    div_cnt  = 0;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_quiet("basic", 200);
    checks += 2;
    if (done_cnt - base != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", done_cnt - base); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int base = done_cnt;
    int n = 0;
    rx = 1'b0;
    while (n < 3) begin
      cycle();
      if (b_tick) n++;
    end
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b expected 1", rx_busy); end
    send_bit(1'b1);
    send_bit(1'b1);
    checks += 3;
    if (done_cnt != base) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", done_cnt - base); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_rx_data: got %02h expected a5", rx_data); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_parity_odd();
    int base = done_cnt;
    send_frame(8'h01, 2'b01, 1'b0, 1'b1);
    send_frame(8'h01, 2'b01, 1'b1, 1'b1);
    send_bit(1'b1);
    wait_quiet("parity_odd", 200);
    checks++;
    if (done_cnt - base != 2) begin errors++; $display("FAIL parity_odd_pulses: got %0d expected 2", done_cnt - base); end
  endtask

  task automatic test_parity_even();
    int base = done_cnt;
    send_frame(8'h03, 2'b10, 1'b0, 1'b1);
    send_frame(8'h07, 2'b10, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_quiet("parity_even", 200);
    checks++;
    if (done_cnt - base != 2) begin errors++; $display("FAIL parity_even_pulses: got %0d expected 2", done_cnt - base); end
  endtask

  task automatic test_break();
    int base = done_cnt;
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0);
    repeat (40) send_bit(1'b0);
    checks += 3;
    if (done_cnt - base != 1) begin errors++; $display("FAIL break_pulses: got %0d expected 1", done_cnt - base); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", rx_busy); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL break_pending: got %0d expected 0", exp_q.size()); end
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_quiet("break_recover", 200);
    checks++;
    if (done_cnt - base != 2) begin errors++; $display("FAIL break_recover_pulses: got %0d expected 2", done_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int base = done_cnt;
    logic [7:0] d = 8'h5A;
    int n = 0;
    parity = 2'b00;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    while (n < 5) begin
      cycle();
      if (b_tick) n++;
    end
    a_resetn = 1'b0;
    rx = 1'b1;
    cycle();
    checks += 2;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_mid_rx_data: got %02h expected 00", rx_data); end
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", rx_busy); end
    a_resetn = 1'b1;
    send_bit(1'b1);
    checks++;
    if (done_cnt != base) begin errors++; $display("FAIL reset_mid_aborted: got %0d pulses expected 0", done_cnt - base); end
    send_frame(8'h81, 2'b00, 1'b0, 1'b1);
    send_bit(1'b1);
    wait_quiet("reset_mid", 200);
    checks += 2;
    if (rx_data !== 8'h81) begin errors++; $display("FAIL reset_mid_rx_data_after: got %02h expected 81", rx_data); end
    if (done_cnt - base != 1) begin errors++; $display("FAIL reset_mid_pulses: got %0d expected 1", done_cnt - base); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [1:0] mode;
    int base;
    int nbytes;
    tick_div = 1;
    div_cnt  = 0;
    for (int m = 0; m < 4; m++) begin
      mode   = 2'(m);
      nbytes = (m == 3) ? 8 : 64;
      base   = done_cnt;
      for (int i = 0; i < nbytes; i++) begin
        d = 8'($urandom_range(0, 255));
        send_frame(d, mode, good_pbit(d, mode), 1'b1);
      end
      send_bit(1'b1);
      wait_quiet("loopback", 200);
      checks++;
      if (done_cnt - base != nbytes) begin
        errors++;
        $display("FAIL loopback_pulses mode=%0d: got %0d expected %0d", m, done_cnt - base, nbytes);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity_odd();
    test_parity_even();
    test_break();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
